// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets two requesters share one
// single-ported 16-bit-word data memory.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req0/1, we0/1         request and write-enable per requester (held until done)
//   addr0/1, wdata0/1     byte address (word aligned) and write data per requester
//   done0/1, err0/1       one-cycle completion pulse and reject flag per requester
//   rdata0/1              last read result per requester
//   memRead, memWrite     data memory enables (only one, only during ISSUE)
//   address, write_data   data memory address / write data (hold between accesses)
//   read_data             data memory read port, valid the edge after memRead
//
// A legal transaction walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE, so a new
// grant is possible at most once every four cycles. An illegal address skips
// the memory entirely and goes IDLE -> RESP with err set.
module dmem_arbiter #(
  parameter logic [15:0] ADDR_MAX = 16'd1022
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] address,
  output logic [15:0] write_data,
  input  logic [15:0] read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // ptr names the requester that wins when both ask at once.
  logic        ptr;
  logic        win;
  logic        win_we;

  logic        any_req;
  logic        grant_id;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        legal;

  // Grant selection and next-state logic.
  always_comb begin
    any_req  = req0 | req1;
    grant_id = 1'b0;
    if (req0 && req1) begin
      grant_id = ptr;
    end else if (req1) begin
      grant_id = 1'b1;
    end

    sel_we    = grant_id ? we1    : we0;
    sel_addr  = grant_id ? addr1  : addr0;
    sel_wdata = grant_id ? wdata1 : wdata0;
    legal     = (sel_addr[0] == 1'b0) && (sel_addr <= ADDR_MAX);

    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = legal ? ISSUE : RESP;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs. Everything is set on the edge that enters the state
  // in which it must be visible: memory enables on the grant edge (seen in
  // ISSUE), done/err/rdata on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      win        <= 1'b0;
      win_we     <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      address    <= 16'h0000;
      write_data <= 16'h0000;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 16'h0000;
      rdata1     <= 16'h0000;
    end else begin
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;

      case (state)
        // Grant: latch the winner, rotate priority to the other requester.
        IDLE: begin
          if (any_req) begin
            win    <= grant_id;
            win_we <= sel_we;
            ptr    <= ~grant_id;
            if (legal) begin
              memRead    <= ~sel_we;
              memWrite   <= sel_we;
              address    <= sel_addr;
              write_data <= sel_wdata;
            end else if (grant_id) begin
              done1  <= 1'b1;
              err1   <= 1'b1;
              rdata1 <= 16'h0000;
            end else begin
              done0  <= 1'b1;
              err0   <= 1'b1;
              rdata0 <= 16'h0000;
            end
          end
        end

        // Memory has returned data for a read issued in the previous cycle.
        WAIT: begin
          if (win) begin
            done1 <= 1'b1;
            if (!win_we) rdata1 <= read_data;
          end else begin
            done0 <= 1'b1;
            if (!win_we) rdata0 <= read_data;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [15:0] ADDR_MAX_REF = 16'd1022;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic        memRead, memWrite;
  logic [15:0] address, write_data;
  logic [15:0] read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_MAX(16'd1022)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .memRead(memRead), .memWrite(memWrite),
    .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  // Data memory: word i initially holds i.
  logic [15:0] mem [0:511];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'(i);
      mem_ready <= 1'b1;
    end else begin
      if (memWrite) mem[address[9:1]] <= write_data;
      if (memRead)  read_data <= mem[address[9:1]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Transaction-level reference: tracks when the next grant may happen and
  // the edge on which each grant's response and memory access appear.
  int          e;
  bit          ptr_m;
  int          busy_until, done_edge, issue_edge;
  bit          id_m, we_m, err_m;
  logic [15:0] rval_m, exp_addr, exp_wd;
  logic [15:0] exp_rd [2];
  logic [15:0] ref_mem [512];

  task automatic model_step();
    bit          w;
    bit          ww;
    logic [15:0] a, d;
    if (!rst_n) begin
      ptr_m      = 1'b0;
      busy_until = e + 1;
      done_edge  = -1;
      issue_edge = -1;
      exp_rd[0]  = 16'h0000;
      exp_rd[1]  = 16'h0000;
      exp_addr   = 16'h0000;
      exp_wd     = 16'h0000;
    end else begin
      if (e >= busy_until && (req0 || req1)) begin
        if (req0 && req1) w = ptr_m; else w = req1;
        ptr_m = !w;
        a  = w ? addr1 : addr0;
        d  = w ? wdata1 : wdata0;
        ww = w ? we1 : we0;
        id_m = w;
        we_m = ww;
        if (a[0] == 1'b0 && a <= ADDR_MAX_REF) begin
          busy_until = e + 4;
          done_edge  = e + 2;
          issue_edge = e;
          err_m      = 1'b0;
          exp_addr   = a;
          exp_wd     = d;
          rval_m     = ref_mem[a[9:1]];
          if (ww) ref_mem[a[9:1]] = d;
        end else begin
          busy_until = e + 2;
          done_edge  = e;
          err_m      = 1'b1;
        end
      end
      if (done_edge == e) begin
        if (err_m) exp_rd[id_m] = 16'h0000;
        else if (!we_m) exp_rd[id_m] = rval_m;
      end
    end
  endtask

  task automatic check_all();
    check_eq("done0",      16'(done0),    16'(done_edge == e && id_m == 1'b0));
    check_eq("done1",      16'(done1),    16'(done_edge == e && id_m == 1'b1));
    check_eq("err0",       16'(err0),     16'(done_edge == e && id_m == 1'b0 && err_m));
    check_eq("err1",       16'(err1),     16'(done_edge == e && id_m == 1'b1 && err_m));
    check_eq("rdata0",     rdata0,        exp_rd[0]);
    check_eq("rdata1",     rdata1,        exp_rd[1]);
    check_eq("memRead",    16'(memRead),  16'(issue_edge == e && !we_m));
    check_eq("memWrite",   16'(memWrite), 16'(issue_edge == e && we_m));
    check_eq("address",    address,       exp_addr);
    check_eq("write_data", write_data,    exp_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    e++;
  endtask

  task automatic set_req(input bit r, input bit v, input bit w, input logic [15:0] a, input logic [15:0] d);
    if (r) begin req1 = v; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = v; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic issue(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    int n;
    set_req(r, 1'b1, w, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(r ? done1 : done0) && n < 12);
    if (n >= 12) check_eq("issue_timeout", 16'd0, 16'd1);
    set_req(r, 1'b0, w, a, d);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'($urandom_range(0, 31) * 2 + 1);
      1:       return 16'h0400 + 16'($urandom_range(0, 100) * 2);
      2:       return 16'd1022;
      3:       return 16'd1024;
      4:       return 16'($urandom);
      default: return 16'($urandom_range(0, 31) * 2);
    endcase
  endfunction

  initial begin
    int n;
    int last;
    bit nxt;
    for (int i = 0; i < 512; i++) ref_mem[i] = 16'(i);
    e = 0; ptr_m = 0; busy_until = 0; done_edge = -1; issue_edge = -1;
    id_m = 0; we_m = 0; err_m = 0; rval_m = 0;
    exp_addr = 0; exp_wd = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    rst_n = 1'b0;
    set_req(0, 0, 0, 16'h0, 16'h0);
    set_req(1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Read of initialised word 3.
    issue(0, 0, 16'h0006, 16'h0000);
    check_eq("read6_rdata0", rdata0, 16'h0003);
    // Write then read back on requester 1.
    issue(1, 1, 16'h0010, 16'hBEEF);
    issue(1, 0, 16'h0010, 16'h0000);
    check_eq("wr_rd_rdata1", rdata1, 16'hBEEF);
    // Misaligned and out-of-range reads are rejected with rdata cleared.
    issue(0, 0, 16'h0007, 16'h0000);
    check_eq("odd_rdata0", rdata0, 16'h0000);
    issue(0, 0, 16'd1022, 16'h0000);
    check_eq("max_rdata0", rdata0, 16'h01FF);
    issue(0, 0, 16'h0400, 16'h0000);
    check_eq("over_rdata0", rdata0, 16'h0000);
    issue(1, 1, 16'hFFFE, 16'h1234);
    tick();

    // Both requesting continuously from reset: grants alternate, 4 cycles apart.
    rst_n = 1'b0;
    set_req(0, 1, 0, 16'h0002, 16'h0);
    set_req(1, 1, 0, 16'h0004, 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    nxt = 1'b0;
    last = -1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done0 || done1) begin
        check_eq("alt_id", 16'(done1), 16'(nxt));
        nxt = !nxt;
        if (last >= 0) check_eq("alt_gap", 16'(e - last), 16'd4);
        last = e;
      end
    end
    check_eq("alt_seen", 16'(last >= 0), 16'd1);
    set_req(0, 0, 0, 16'h0, 16'h0);
    set_req(1, 0, 0, 16'h0, 16'h0);
    repeat (5) tick();

    // Reset landing in WAIT of a read aborts it; pointer restarts at 0.
    set_req(1, 1, 0, 16'h0008, 16'h0);
    n = 0;
    do begin tick(); n++; end while (!memRead && n < 8);
    check_eq("abort_issue_seen", 16'(memRead), 16'd1);
    set_req(1, 0, 0, 16'h0008, 16'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1, 0, 16'h000C, 16'h0);
    set_req(1, 1, 0, 16'h000E, 16'h0);
    n = 0;
    do begin tick(); n++; end while (!(done0 || done1) && n < 10);
    check_eq("post_reset_winner0", 16'(done0), 16'd1);
    check_eq("post_reset_rdata0", rdata0, 16'h0006);
    set_req(0, 0, 0, 16'h0, 16'h0);
    set_req(1, 0, 0, 16'h0, 16'h0);
    repeat (4) tick();

    // Randomised traffic, occasional drops before done and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < 2; r++) begin
        bit cur_req;
        bit cur_done;
        cur_req  = r ? req1 : req0;
        cur_done = r ? done1 : done0;
        if (cur_done || !cur_req) begin
          if (cur_done || $urandom_range(0, 2) == 0)
            set_req(r[0], ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    rand_addr(), 16'($urandom));
        end else if ($urandom_range(0, 19) == 0) begin
          set_req(r[0], 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
